// File: rtl/mem_arb_pkg.sv
// Shared types and default sizing for the two-port memory arbiter.
package mem_arb_pkg;

  localparam int DEF_DW     = 8;
  localparam int DEF_AW     = 4;
  localparam int DEF_RD_LAT = 2;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    RD_DONE = 2'd2
  } arb_state_t;

  typedef logic port_id_t;

  localparam port_id_t PORT0 = 1'b0;
  localparam port_id_t PORT1 = 1'b1;

endpackage

// File: rtl/mem_arbiter_if.sv
// Two requester ports plus the shared read-return path of mem_arbiter.
interface mem_arbiter_if
  import mem_arb_pkg::*;
#(
  parameter int DW = DEF_DW,
  parameter int AW = DEF_AW
);

  // reqN/weN/addrN/wdataN are held stable until gntN; gntN is the accept strobe
  // for that cycle. rvalidN is a one-cycle pulse qualifying the shared rdata.
  logic          req0,   req1;
  logic          we0,    we1;
  logic [AW-1:0] addr0,  addr1;
  logic [DW-1:0] wdata0, wdata1;
  logic          gnt0,   gnt1;
  logic          rvalid0, rvalid1;
  logic [DW-1:0] rdata;
  logic          busy;

  modport master (
    output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1,
    input  gnt0, gnt1, rvalid0, rvalid1, rdata, busy
  );

  modport slave (
    input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1,
    output gnt0, gnt1, rvalid0, rvalid1, rdata, busy
  );

endinterface

// File: rtl/mem.sv
// Single-port synchronous RAM: registered read stage, oce gates the output.
module mem #(
  parameter int DW = 8,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ce,
  input  logic          wre,
  input  logic          oce,
  input  logic [AW-1:0] ad,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] dout
);

  logic [DW-1:0] ram [2**AW];
  logic [DW-1:0] q;

  always_ff @(posedge clk)
    if (ce && wre) ram[ad] <= din;

  // Only the read register is reset; array contents survive reset.
  always_ff @(posedge clk or posedge rst)
    if (rst)             q <= '0;
    else if (ce && !wre) q <= ram[ad];

  assign dout = oce ? q : '0;

endmodule

// File: rtl/mem_arbiter.sv
// Two-port arbiter in front of a single-port RAM. Define MEM_ARB_RR_EN for
// round-robin arbitration; otherwise port 0 has fixed priority.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int DW     = DEF_DW,
  parameter int AW     = DEF_AW,
  parameter int RD_LAT = DEF_RD_LAT
) (
  input  logic          clk,
  input  logic          rst,
  mem_arbiter_if.slave  bus,
  output arb_state_t    state_dbg
);

  localparam int CW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

  arb_state_t    state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  port_id_t      port, port_nxt;
  logic          win0, sel1, gnt0, gnt1, any_gnt;
  logic          g_we, wre, oce, rv0, rv1, busy;
  logic [AW-1:0] g_ad, ad, ad_q;
  logic [DW-1:0] g_din, dout, rdata_c, rdata_q;

`ifdef MEM_ARB_RR_EN
  port_id_t prio;

  // The port just granted drops to lower priority.
  always_ff @(posedge clk or negedge rst)
    if (!rst)               prio <= PORT0;
    else if (gnt0 || gnt1)  prio <= gnt0 ? PORT1 : PORT0;

  assign win0 = bus.req0 && (!bus.req1 || prio == PORT0);
`else
  assign win0 = bus.req0;
`endif

  assign sel1  = bus.req1 && !win0;
  assign g_we  = sel1 ? bus.we1    : bus.we0;
  assign g_ad  = sel1 ? bus.addr1  : bus.addr0;
  assign g_din = sel1 ? bus.wdata1 : bus.wdata0;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    port_nxt  = port;
    gnt0      = 1'b0;
    gnt1      = 1'b0;
    busy      = 1'b0;
    oce       = 1'b0;
    rv0       = 1'b0;
    rv1       = 1'b0;
    case (state)
      IDLE: begin
        gnt0 = rst && win0;
        gnt1 = rst && sel1;
        if ((gnt0 || gnt1) && !g_we) begin
          port_nxt  = sel1 ? PORT1 : PORT0;
          cnt_nxt   = CW'(RD_LAT - 1);
          state_nxt = (RD_LAT == 1) ? RD_DONE : RD_WAIT;
        end
      end
      RD_WAIT: begin
        busy    = 1'b1;
        cnt_nxt = cnt - 1'b1;
        if (cnt == CW'(1)) state_nxt = RD_DONE;
      end
      RD_DONE: begin
        busy      = 1'b1;
        oce       = 1'b1;
        rv0       = (port == PORT0);
        rv1       = (port == PORT1);
        cnt_nxt   = '0;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Outside a grant the address is held so the read register keeps its word.
  assign any_gnt = gnt0 || gnt1;
  assign wre     = any_gnt && g_we;
  assign ad      = any_gnt ? g_ad : ad_q;
  assign rdata_c = (rv0 || rv1) ? dout : rdata_q;

  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state   <= IDLE;
      cnt     <= '0;
      port    <= PORT0;
      ad_q    <= '0;
      rdata_q <= '0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      port    <= port_nxt;
      ad_q    <= ad;
      rdata_q <= rdata_c;
    end

  mem #(.DW(DW), .AW(AW)) u_mem (
    .clk  (clk),
    .rst  (~rst),
    .ce   (1'b1),
    .wre  (wre),
    .oce  (oce),
    .ad   (ad),
    .din  (g_din),
    .dout (dout)
  );

  assign bus.gnt0    = gnt0;
  assign bus.gnt1    = gnt1;
  assign bus.rvalid0 = rv0;
  assign bus.rvalid1 = rv1;
  assign bus.rdata   = rdata_c;
  assign bus.busy    = busy;
  assign state_dbg   = state;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: cycle-level reference model plus rvalid scoreboard.
module tb_mem_arbiter;
  import mem_arb_pkg::*;

  localparam int DW     = DEF_DW;
  localparam int AW     = DEF_AW;
  localparam int RD_LAT = DEF_RD_LAT;
  localparam int W      = 33 + DW;
`ifdef MEM_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  typedef struct {
    bit            v;
    bit            we;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } cmd_t;

  logic       clk;
  logic       rst;
  arb_state_t state_dbg;

  mem_arbiter_if #(.DW(DW), .AW(AW)) bus ();

  mem_arbiter #(.DW(DW), .AW(AW), .RD_LAT(RD_LAT)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  // ---------------- clock / cycle counter ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- model state ----------------
  int            vectors = 0;
  int            miscompares = 0;
  logic [W-1:0]  exp_q[$];          // {rvalid cycle, port, data}
  logic [DW-1:0] model_mem [2**AW];
  logic [DW-1:0] last_rdata;
  cmd_t          pc [2];
  int            busy_left;
  int            last_gnt;
  int            g0_seen;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s @cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // Simultaneous requests: fixed build favours port 0; round-robin favours
  // whichever port was not granted last.
  function automatic int pick(bit r0, bit r1);
    if (r0 && r1) return (RR && last_gnt == 0) ? 1 : 0;
    if (r0) return 0;
    if (r1) return 1;
    return -1;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive();
    bus.req0 = pc[0].v; bus.we0 = pc[0].we; bus.addr0 = pc[0].a; bus.wdata0 = pc[0].d;
    bus.req1 = pc[1].v; bus.we1 = pc[1].we; bus.addr1 = pc[1].a; bus.wdata1 = pc[1].d;
  endtask

  task automatic issue(int p, bit we, int a, int d);
    pc[p].v  = 1'b1;
    pc[p].we = we;
    pc[p].a  = AW'(a);
    pc[p].d  = DW'(d);
  endtask

  task automatic step();
    int         g;
    arb_state_t es;
    @(negedge clk);
    drive();
    #2;
    g  = (busy_left > 0) ? -1 : pick(pc[0].v, pc[1].v);
    es = (busy_left == 0) ? IDLE : ((busy_left == 1) ? RD_DONE : RD_WAIT);
    check("gnt0",  32'(bus.gnt0),  32'(g == 0));
    check("gnt1",  32'(bus.gnt1),  32'(g == 1));
    check("busy",  32'(bus.busy),  32'(busy_left > 0));
    check("state", 32'(state_dbg), 32'(es));
    g0_seen += int'(bus.gnt0);
    if (busy_left > 0) busy_left--;
    if (g >= 0) begin
      last_gnt = g;
      if (pc[g].we) model_mem[pc[g].a] = pc[g].d;
      else begin
        exp_q.push_back({32'(cyc + RD_LAT), g[0], model_mem[pc[g].a]});
        busy_left = RD_LAT;
      end
      pc[g].v = 1'b0;
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 60 && (pc[0].v || pc[1].v || busy_left > 0); i++) step();
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b0;
    pc[0].v = 1'b0;
    pc[1].v = 1'b0;
    // Requests held high during reset must still see no grant.
    bus.req0 = 1'b1; bus.we0 = 1'b1; bus.req1 = 1'b1; bus.we1 = 1'b0;
    exp_q.delete();
    busy_left  = 0;
    last_gnt   = 1;
    last_rdata = '0;
    #1;
    check("rst_gnt",    32'({bus.gnt1, bus.gnt0}),       32'd0);
    check("rst_busy",   32'(bus.busy),                   32'd0);
    check("rst_rvalid", 32'({bus.rvalid1, bus.rvalid0}), 32'd0);
    check("rst_rdata",  32'(bus.rdata),                  32'd0);
    check("rst_state",  32'(state_dbg),                  32'(IDLE));
    repeat (2) @(negedge clk);
    drive();
    rst = 1'b1;
  endtask

  // ---------------- monitor / scoreboard ----------------
  initial begin
    logic [W-1:0] e;
    logic [1:0]   exp_rv;
    forever begin
      @(posedge clk);
      #1;
      exp_rv = 2'b00;
      if (exp_q.size() > 0 && int'(exp_q[0][W-1 -: 32]) == cyc) begin
        e          = exp_q.pop_front();
        exp_rv     = e[DW] ? 2'b10 : 2'b01;
        last_rdata = e[DW-1:0];
      end
      check("rvalid", 32'({bus.rvalid1, bus.rvalid0}), 32'(exp_rv));
      check("rdata",  32'(bus.rdata),                  32'(last_rdata));
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    rst        = 1'b0;
    busy_left  = 0;
    last_gnt   = 1;
    last_rdata = '0;
    g0_seen    = 0;
    for (int p = 0; p < 2; p++) pc[p] = '{v: 1'b0, we: 1'b0, a: '0, d: '0};
    drive();
    apply_reset();

    // write 3 = A5 then read it back on port 0
    issue(0, 1'b1, 3, 'hA5); step();
    issue(0, 1'b0, 3, 0);    step();
    drain();

    // back-to-back fill, data = addr*3, then readback
    g0_seen = 0;
    for (int a = 0; a < 16; a++) begin
      issue(0, 1'b1, a, a * 3);
      step();
    end
    check("fill_grants", 32'(g0_seen), 32'd16);
    for (int a = 0; a < 16; a++) begin
      issue(a % 2, 1'b0, a, 0);
      drain();
    end

    // read the cycle right after a write to the same address
    issue(0, 1'b1, 7, 'h3C); step();
    issue(0, 1'b0, 7, 0);    step();
    drain();

    // both ports writing, held for four cycles
    for (int i = 0; i < 4; i++) begin
      if (!pc[0].v) issue(0, 1'b1, 8 + i,  'h40 + i);
      if (!pc[1].v) issue(1, 1'b1, 12 + i, 'h80 + i);
      step();
    end
    drain();

    // port 1 read while port 0 write waits behind it
    issue(1, 1'b0, 5, 0);    step();
    issue(0, 1'b1, 9, 'h77); drain();

    // reset one cycle after a read grant, then data still readable
    issue(0, 1'b0, 3, 0); step();
    apply_reset();
    issue(1, 1'b0, 3, 0); drain();
    issue(0, 1'b0, 7, 0); drain();

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      for (int p = 0; p < 2; p++)
        if (!pc[p].v && $urandom_range(0, 3) != 0)
          issue(p, 1'($urandom_range(0, 1)), int'($urandom_range(0, 15)),
                int'($urandom_range(0, 255)));
      step();
    end
    drain();
    repeat (RD_LAT + 2) step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
- REQ-001 SHALL have parameter DW, default 8, meaning data width of each port and of the memory.
- REQ-002 SHALL have parameter AW, default 4, meaning address width; the memory depth is 2^AW words.
- REQ-003 SHALL have parameter RD_LAT, default 2, meaning clock edges from read grant to valid data (minimum 1).
- REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
- REQ-005 SHALL have port rst, input, 1 bit: one clock; reset is asynchronous and active-low.
- REQ-006 SHALL have ports req0/req1, input, 1 bit each: the port requests an access.
- REQ-007 SHALL have ports we0/we1, input, 1 bit each: 1 for write, 0 for read.
- REQ-008 SHALL have ports addr0/addr1, input, AW bits each: the access address.
- REQ-009 SHALL have ports wdata0/wdata1, input, DW bits each: the write data.
- REQ-010 SHALL have ports gnt0/gnt1, output, 1 bit each: the command is accepted this cycle.
- REQ-011 SHALL have ports rvalid0/rvalid1, output, 1 bit each: a one-cycle pulse marking read data valid.
- REQ-012 SHALL have port rdata, output, DW bits: read data shared by both ports, qualified by rvalid0/rvalid1.
- REQ-013 SHALL have port busy, output, 1 bit: high while a read is in flight.

Function
- REQ-014 SHALL use three states: IDLE, RD_WAIT and RD_DONE.
- REQ-015 SHALL, in IDLE, raise exactly one gnt combinationally in any cycle where at least one req is high, and none otherwise.
- REQ-016 SHALL drive the memory command (wre, ad, din, ce) from the granted port in its grant cycle, and SHALL capture it at the next edge.
- REQ-017 SHALL keep the state in IDLE after a write grant, so writes sustain one per cycle.
- REQ-018 SHALL go from IDLE to RD_WAIT on a read grant, latch the granted port ID, and load the latency counter with RD_LAT-1.
- REQ-019 SHALL decrement the counter in RD_WAIT and go to RD_DONE when it reaches 0.
- REQ-020 SHALL, in RD_DONE, assert oce and pulse rvalid of the latched port for one cycle with rdata equal to mem dout, then return to IDLE.
- REQ-021 SHALL make rvalid occur exactly RD_LAT edges after the read grant.
- REQ-022 SHALL hold all gnt low in RD_WAIT and RD_DONE, and SHALL raise busy in both states.
- REQ-023 SHALL treat requesters as holding req, we, addr and wdata stable until their gnt; the block SHALL NOT queue commands.
- REQ-024 SHALL hold rdata at its last value when no rvalid is high.
- REQ-025 SHALL return a read issued the cycle after a write to the same address with the new data.
- REQ-026 SHALL give a lone requester a grant in the same cycle regardless of arbitration history.

Reset
- REQ-027 SHALL, while rst=0, force state IDLE, counter 0, priority pointer to port 0, and all gnt, rvalid and busy to 0.
- REQ-028 SHALL also force rdata to 0 while rst=0.
- REQ-029 SHALL drop a read in flight at reset with no rvalid, and SHALL leave memory contents untouched.
- REQ-030 SHALL drive the memory's reset from the inverse of rst.

Configuration
- REQ-031 SHALL, with MEM_ARB_RR_EN defined, use round-robin arbitration on simultaneous requests: the port granted last has lower priority next time.
- REQ-032 SHALL update the round-robin pointer on every grant.
- REQ-033 SHALL, without MEM_ARB_RR_EN, use fixed priority with port 0 always winning, and SHALL have no pointer register.

Structure
- REQ-034 SHALL take the state enum, port-ID type and default DW/AW/RD_LAT constants from a shared package, mem_arb_pkg.
- REQ-035 SHALL contain exactly one sub-module, the existing single-port memory block mem, instantiated as is with ce tied high.

Verification
- REQ-036 SHALL cover: reset, then req0 write addr 3 data 0xA5, then req0 read addr 3 -> gnt0 same cycle each time; rvalid0 exactly 2 edges after the read grant with rdata=0xA5.
- REQ-037 SHALL cover: req0 and req1 both writing, held 4 cycles, with MEM_ARB_RR_EN -> grants 0,1,0,1; without it -> gnt0 only, gnt1 never.
- REQ-038 SHALL cover: req1 read addr 5 while req0 holds a write pending -> gnt0 low in both wait cycles; busy=1 for 2 cycles; gnt0 on the first IDLE cycle.
- REQ-039 SHALL cover: back-to-back writes to addr 0..15 with data = addr*3 -> 16 consecutive grant cycles; readback returns matching values.
- REQ-040 SHALL cover: rst pulled low 1 cycle after a read grant -> no rvalid, busy=0 at once, earlier-written data still readable.
- REQ-041 SHALL cover: write addr 7 = 0x3C, then read addr 7 on the next cycle -> rdata=0x3C.
